// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the reset fetch address, the memory-port width encodings, the
// fetch FSM state encoding, the prefetch queue entry layout and small
// helpers for address alignment and width selection.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0800_0000;

    localparam logic [1:0] MEM_W_BYTE = 2'd0;
    localparam logic [1:0] MEM_W_HALF = 2'd1;
    localparam logic [1:0] MEM_W_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        thumb;
    } fetch_entry_t;

    // Thumb instructions are halfword aligned, ARM instructions word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc, input logic thumb);
        return thumb ? {pc[31:1], 1'b0} : {pc[31:2], 2'b00};
    endfunction

    function automatic logic [1:0] mem_width_for(input logic thumb);
        return thumb ? MEM_W_HALF : MEM_W_WORD;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetched instructions.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   clear_i          empties the queue (wins over push/pop)
//   push_i, push_data_i   write one entry (accepted when not full, or full with pop)
//   pop_i            drop the head entry (ignored when empty)
//   head_o           head entry (registered storage, valid when !empty_o)
//   count_o, empty_o, full_o  occupancy
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // DEPTH is a power of two, so AW-bit pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && !clear_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cpu_prefetch_unit.sv
// Instruction-fetch front end: decoupled fetch into a DEPTH-entry prefetch
// queue, word fetches in ARM state and halfword fetches in Thumb state,
// branch flush with dropping of a response still in flight.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   flush, flush_pc, flush_thumb      redirect request
//   instr_valid/ready/data/pc/thumb   queue head towards decode
//   mem_addr/read/width/rdata/ok      shared memory port
//
// state   | meaning
// --------+------------------------------------------------------------
// S_INIT  | one cycle after reset, no request issued
// S_FETCH | issuing requests while the queue has room
// S_DROP  | request issued before a flush still outstanding; discard it
module cpu_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        flush_thumb,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        instr_thumb,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ok
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic          thumb_q;
    logic          thumb_d;
    logic          mem_read_q;
    logic [31:0]   mem_addr_q;
    logic [1:0]    mem_width_q;

    logic          push;
    logic          pop;
    logic [CW-1:0] count_d;
    logic          room_d;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    always_comb begin
        pop  = !fifo_empty && instr_ready && !flush;
        // In S_FETCH an outstanding request is always at fetch_pc_q.
        push = (state_q == S_FETCH) && mem_read_q && mem_ok && !flush
               && (!fifo_full || pop);

        count_d = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
        // Request for next cycle only if the queue will still have room,
        // so a queued response can never overflow it.
        room_d  = (count_d < CW'(DEPTH));

        if (flush) begin
            fetch_pc_d = align_pc(flush_pc, flush_thumb);
            thumb_d    = flush_thumb;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + (thumb_q ? 32'd2 : 32'd4);
            thumb_d    = thumb_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
            thumb_d    = thumb_q;
        end

        push_entry.data  = thumb_q ? {16'h0000, mem_rdata[15:0]} : mem_rdata;
        push_entry.pc    = fetch_pc_q;
        push_entry.thumb = thumb_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_INIT;
            fetch_pc_q  <= RESET_PC;
            thumb_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= MEM_W_WORD;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            thumb_q    <= thumb_d;
            unique case (state_q)
                S_INIT: begin
                    state_q    <= S_FETCH;
                    mem_read_q <= 1'b0;
                end
                S_FETCH: begin
                    if (mem_read_q && !mem_ok) begin
                        // Request in flight: address and width stay put.
                        if (flush) state_q <= S_DROP;
                    end else begin
                        mem_read_q  <= room_d;
                        mem_addr_q  <= fetch_pc_d;
                        mem_width_q <= mem_width_for(thumb_d);
                    end
                end
                S_DROP: begin
                    // Completion of the stale request also ends the drop,
                    // even if another flush arrives in the same cycle.
                    if (mem_ok) begin
                        state_q     <= S_FETCH;
                        mem_read_q  <= room_d;
                        mem_addr_q  <= fetch_pc_d;
                        mem_width_q <= mem_width_for(thumb_d);
                    end
                end
                default: begin
                    state_q    <= S_INIT;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign instr_valid = !fifo_empty;
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;
    assign instr_thumb = head.thumb;
    assign mem_read    = mem_read_q;
    assign mem_addr    = mem_addr_q;
    assign mem_width   = mem_width_q;

endmodule

// File: tb/tb_cpu_prefetch_unit.sv
`timescale 1ns/1ps
module tb_cpu_prefetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        flush_thumb = 1'b0;
    logic        instr_ready = 1'b0;
    logic        mem_ok = 1'b0;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_thumb;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [1:0]  mem_width;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    assign mem_rdata = memfn(mem_addr);

    cpu_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .flush_thumb (flush_thumb),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_thumb (instr_thumb),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_width   (mem_width),
        .mem_rdata   (mem_rdata),
        .mem_ok      (mem_ok)
    );

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        thumb;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc = RST_PC;
    logic        m_thumb = 1'b0;
    logic        m_drop = 1'b0;
    logic [31:0] m_drop_pc = '0;
    logic        m_drop_thumb = 1'b0;
    int          m_age = 0;

    function automatic ent_t mk(input logic [31:0] pc, input logic th);
        ent_t        e;
        logic [31:0] d;
        d       = memfn(pc);
        e.pc    = pc;
        e.thumb = th;
        e.data  = th ? {16'h0000, d[15:0]} : d;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge, advance the model by
    // the transactions of that cycle, then return at the next falling edge.
    task automatic cyc(input logic fl, input logic [31:0] fpc, input logic fth,
                       input logic rdy, input logic ok);
        logic r;
        logic v;
        flush = fl; flush_pc = fpc; flush_thumb = fth;
        instr_ready = rdy; mem_ok = ok;
        r = mem_read;
        v = instr_valid;
        if (!rstn) begin
            m_q.delete();
            m_pc = RST_PC; m_thumb = 1'b0; m_drop = 1'b0; m_age = 0;
        end else begin
            m_age++;
            if (fl) begin
                if (m_drop) begin
                    if (ok) m_drop = 1'b0;
                end else if (r && !ok) begin
                    m_drop = 1'b1; m_drop_pc = m_pc; m_drop_thumb = m_thumb;
                end
                m_q.delete();
                m_pc    = fth ? {fpc[31:1], 1'b0} : {fpc[31:2], 2'b00};
                m_thumb = fth;
            end else begin
                if (v && rdy && m_q.size() > 0) void'(m_q.pop_front());
                if (r && ok) begin
                    if (m_drop) m_drop = 1'b0;
                    else begin
                        m_q.push_back(mk(m_pc, m_thumb));
                        m_pc = m_pc + (m_thumb ? 32'd2 : 32'd4);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %b expected 0", mem_read); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_width !== 2'd2) begin n_errors++; $display("FAIL reset_width: got %0d expected 2", mem_width); end
        rstn = 1'b1;
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL init_read_c1: got %b expected 0", mem_read); end
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL init_read_c2: got %b expected 1", mem_read); end
        n_checks++; if (mem_addr !== RST_PC) begin n_errors++; $display("FAIL init_addr: got %h expected %h", mem_addr, RST_PC); end
        n_checks++; if (mem_width !== 2'd2) begin n_errors++; $display("FAIL init_width: got %0d expected 2", mem_width); end
    endtask

    task automatic test_fill();
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_read) begin
                n_checks++;
                if (mem_addr !== RST_PC + 32'(4 * acc)) begin
                    n_errors++; $display("FAIL fill_addr: got %h expected %h", mem_addr, RST_PC + 32'(4 * acc));
                end
                acc++;
            end
            cyc(0, 0, 0, 0, 1);
        end
        n_checks++; if (acc !== DEPTH) begin n_errors++; $display("FAIL fill_requests: got %0d expected %0d", acc, DEPTH); end
        n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL fill_read_drop: got %b expected 0", mem_read); end
        n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL fill_valid: got %b expected 1", instr_valid); end
        n_checks++; if (instr_pc !== RST_PC) begin n_errors++; $display("FAIL fill_head_pc: got %h expected %h", instr_pc, RST_PC); end
        n_checks++; if (instr_data !== memfn(RST_PC)) begin n_errors++; $display("FAIL fill_head_data: got %h expected %h", instr_data, memfn(RST_PC)); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = RST_PC;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, instr_valid); end
            n_checks++; if (instr_pc !== exp_pc) begin n_errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, instr_pc, exp_pc); end
            n_checks++; if (instr_data !== memfn(exp_pc)) begin n_errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, instr_data, memfn(exp_pc)); end
            if (i >= 1) begin
                n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL stream_read[%0d]: got %b expected 1", i, mem_read); end
            end
            exp_pc = exp_pc + 32'd4;
            cyc(0, 0, 0, 1, 1);
        end
    endtask

    task automatic test_flush_drop();
        logic [31:0] old_pc;
        logic [31:0] d;
        cyc(0, 0, 0, 0, 0);
        old_pc = m_pc;
        n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL drop_pre_read: got %b expected 1", mem_read); end
        cyc(1, 32'h0800_0101, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_read !== 1'b1 || mem_addr !== old_pc || mem_width !== 2'd2) begin
                n_errors++; $display("FAIL drop_hold[%0d]: got read=%b addr=%h width=%0d expected read=1 addr=%h width=2", i, mem_read, mem_addr, mem_width, old_pc);
            end
            n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL drop_valid[%0d]: got %b expected 0", i, instr_valid); end
            cyc(0, 0, 0, 0, (i == 2));
        end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL drop_discard: got valid=%b expected 0", instr_valid); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0800_0100 + 32'(2 * i) || mem_width !== 2'd1) begin
                n_errors++; $display("FAIL thumb_req[%0d]: got read=%b addr=%h width=%0d expected read=1 addr=%h width=1", i, mem_read, mem_addr, mem_width, 32'h0800_0100 + 32'(2 * i));
            end
            cyc(0, 0, 0, 0, 1);
        end
        d = memfn(32'h0800_0100);
        n_checks++; if (instr_pc !== 32'h0800_0100 || instr_thumb !== 1'b1) begin n_errors++; $display("FAIL thumb_head: got pc=%h thumb=%b expected pc=08000100 thumb=1", instr_pc, instr_thumb); end
        n_checks++; if (instr_data !== {16'h0000, d[15:0]}) begin n_errors++; $display("FAIL thumb_data: got %h expected %h", instr_data, {16'h0000, d[15:0]}); end
    endtask

    task automatic test_flush_same_cycle();
        n_checks++; if (instr_valid !== 1'b1 || mem_read !== 1'b1) begin n_errors++; $display("FAIL samecyc_pre: got valid=%b read=%b expected 1 1", instr_valid, mem_read); end
        cyc(1, 32'h0800_2003, 0, 1, 1);
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL samecyc_valid: got %b expected 0", instr_valid); end
        n_checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0800_2000 || mem_width !== 2'd2) begin
            n_errors++; $display("FAIL samecyc_req: got read=%b addr=%h width=%0d expected read=1 addr=08002000 width=2", mem_read, mem_addr, mem_width);
        end
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0800_2000 || instr_thumb !== 1'b0) begin
            n_errors++; $display("FAIL samecyc_head: got valid=%b pc=%h thumb=%b expected 1 08002000 0", instr_valid, instr_pc, instr_thumb);
        end
        n_checks++; if (instr_data !== memfn(32'h0800_2000)) begin n_errors++; $display("FAIL samecyc_data: got %h expected %h", instr_data, memfn(32'h0800_2000)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc = 32'h0800_2000;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
        n_checks++; if (mem_read !== 1'b0 || instr_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_full: got read=%b valid=%b expected 0 1", mem_read, instr_valid); end
        cyc(0, 0, 0, 1, 0);
        exp_pc = exp_pc + 32'd4;
        n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL b2b_reopen: got %b expected 1", mem_read); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
                n_errors++; $display("FAIL b2b_order[%0d]: got valid=%b pc=%h expected 1 %h", i, instr_valid, instr_pc, exp_pc);
            end
            n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL b2b_read[%0d]: got %b expected 1", i, mem_read); end
            exp_pc = exp_pc + 32'd4;
            cyc(0, 0, 0, 1, 1);
        end
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL b2b_count_kept: got read=%b expected 0", mem_read); end
    endtask

    task automatic test_reset_mid_stall();
        cyc(0, 0, 0, 1, 0);
        n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL rst_stall_pre: got %b expected 1", mem_read); end
        rstn = 1'b0;
        cyc(0, 0, 0, 0, 0);
        rstn = 1'b1;
        n_checks++; if (mem_read !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h0) begin
            n_errors++; $display("FAIL rst_stall_clear: got read=%b valid=%b addr=%h expected 0 0 0", mem_read, instr_valid, mem_addr);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (mem_read !== 1'b1 || mem_addr !== RST_PC || mem_width !== 2'd2) begin
            n_errors++; $display("FAIL rst_restart: got read=%b addr=%h width=%0d expected 1 %h 2", mem_read, mem_addr, mem_width, RST_PC);
        end
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== RST_PC || instr_thumb !== 1'b0) begin
            n_errors++; $display("FAIL rst_head: got valid=%b pc=%h thumb=%b expected 1 %h 0", instr_valid, instr_pc, instr_thumb, RST_PC);
        end
    endtask

    task automatic test_random();
        logic        exp_read;
        logic [31:0] exp_addr;
        logic [1:0]  exp_width;
        logic        fl;
        logic [31:0] fpc;
        for (int i = 0; i < 1500; i++) begin
            exp_read  = (m_age >= 2) && (m_drop || m_q.size() < DEPTH);
            exp_addr  = m_drop ? m_drop_pc : m_pc;
            exp_width = (m_drop ? m_drop_thumb : m_thumb) ? 2'd1 : 2'd2;
            n_checks++; if (instr_valid !== (m_q.size() > 0)) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, instr_valid, m_q.size() > 0); end
            n_checks++; if (mem_read !== exp_read) begin n_errors++; $display("FAIL rnd_read[%0d]: got %b expected %b", i, mem_read, exp_read); end
            if (exp_read) begin
                n_checks++; if (mem_addr !== exp_addr || mem_width !== exp_width) begin
                    n_errors++; $display("FAIL rnd_req[%0d]: got addr=%h width=%0d expected addr=%h width=%0d", i, mem_addr, mem_width, exp_addr, exp_width);
                end
            end
            if (m_q.size() > 0) begin
                n_checks++; if (instr_pc !== m_q[0].pc || instr_data !== m_q[0].data || instr_thumb !== m_q[0].thumb) begin
                    n_errors++; $display("FAIL rnd_head[%0d]: got pc=%h data=%h thumb=%b expected pc=%h data=%h thumb=%b",
                                         i, instr_pc, instr_data, instr_thumb, m_q[0].pc, m_q[0].data, m_q[0].thumb);
                end
            end
            rstn = ($urandom_range(0, 199) != 0);
            fl   = (m_age >= 2) && ($urandom_range(0, 19) == 0);
            fpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc(fl, fpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
        end
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_stream();
        test_flush_drop();
        test_flush_same_cycle();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
